// File: rtl/i2c_write_sequencer_if.sv
// Bus bundle between the write sequencer, its byte producer and the I2C master core.
// The sequencer uses the slave view; whatever drives it uses the master view.
interface i2c_write_sequencer_if;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       FULL;
  logic       GO;
  logic [6:0] SLAVE;
  logic [4:0] LEN;
  logic       IDLE;
  logic       DONE;
  logic       NACK;
  logic       M_START;
  logic [7:0] M_ADDR;
  logic [7:0] M_DATA;
  logic       M_BUSY;
  logic       M_RUNNING;
  logic       M_ADDR_SENT;

  modport slave (
    input  WR_EN, WR_DATA, GO, SLAVE, LEN, M_BUSY, M_RUNNING, M_ADDR_SENT,
    output FULL, IDLE, DONE, NACK, M_START, M_ADDR, M_DATA
  );

  modport master (
    output WR_EN, WR_DATA, GO, SLAVE, LEN, M_BUSY, M_RUNNING, M_ADDR_SENT,
    input  FULL, IDLE, DONE, NACK, M_START, M_ADDR, M_DATA
  );
endinterface

// File: rtl/i2c_write_sequencer.sv
// Buffers payload bytes and feeds them one at a time to an I2C master as a single
// write transaction, reporting completion (DONE) or slave no-ack (NACK).
module i2c_write_sequencer #(
  parameter int DEPTH = 16
) (
  input logic                  CLK,
  input logic                  ASYNC_RST_L,
  i2c_write_sequencer_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_RUN,
    S_WAIT_RDY,
    S_HANDOFF,
    S_STOP,
    S_FLUSH
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    remaining_q, remaining_d;
  logic          m_start_q, m_start_d;
  logic [7:0]    m_addr_q, m_addr_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          done_q, done_d;
  logic          nack_q, nack_d;

  logic full;
  logic push;
  logic pop;
  logic rdy;
  logic go_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign push  = bus.WR_EN & ~full;
  assign rdy   = bus.M_RUNNING & bus.M_ADDR_SENT & ~bus.M_BUSY;
  // LEN is checked against the current occupancy so the transaction can never underflow
  assign go_ok = bus.GO && (bus.LEN != 5'd0) && (int'(bus.LEN) <= DEPTH)
                 && (int'(bus.LEN) <= int'(count_q));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    m_start_d   = m_start_q;
    m_addr_d    = m_addr_q;
    m_data_d    = m_data_q;
    done_d      = 1'b0;
    nack_d      = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_ok) begin
          m_addr_d    = {bus.SLAVE, 1'b0};
          remaining_d = bus.LEN;
          m_start_d   = 1'b1;
          state_d     = S_ARM;
        end
      end
      S_ARM: begin
        state_d = bus.M_RUNNING ? S_WAIT_RDY : S_WAIT_RUN;
      end
      S_WAIT_RUN: begin
        if (bus.M_RUNNING) state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        // the master leaving RUNNING before we asked for STOP means the slave did not ack
        if (!bus.M_RUNNING) begin
          m_start_d = 1'b0;
          state_d   = S_FLUSH;
        end else if (rdy) begin
          if (remaining_q != 5'd0) begin
            m_data_d    = mem_q[rd_ptr_q];
            pop         = 1'b1;
            remaining_d = remaining_q - 5'd1;
            state_d     = S_HANDOFF;
          end else begin
            m_start_d = 1'b0;
            state_d   = S_STOP;
          end
        end
      end
      S_HANDOFF: begin
        if (!bus.M_RUNNING) begin
          m_start_d = 1'b0;
          state_d   = S_FLUSH;
        end else if (bus.M_BUSY) begin
          state_d = S_WAIT_RDY;
        end
      end
      S_STOP: begin
        if (!bus.M_RUNNING) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (remaining_q != 5'd0) begin
          pop         = 1'b1;
          remaining_d = remaining_q - 5'd1;
        end else begin
          nack_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Payload storage carries no reset; emptiness is defined by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.WR_DATA;
  end

  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      m_start_q   <= 1'b0;
      m_addr_q    <= '0;
      m_data_q    <= '0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      m_start_q   <= m_start_d;
      m_addr_q    <= m_addr_d;
      m_data_q    <= m_data_d;
      done_q      <= done_d;
      nack_q      <= nack_d;
    end
  end

  assign bus.FULL    = full;
  assign bus.IDLE    = (state_q == S_IDLE);
  assign bus.DONE    = done_q;
  assign bus.NACK    = nack_q;
  assign bus.M_START = m_start_q;
  assign bus.M_ADDR  = m_addr_q;
  assign bus.M_DATA  = m_data_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer: a responding I2C master model, a transaction-level
// payload model checked every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_i2c_write_sequencer;
  localparam int DEPTH = 16;

  logic CLK = 1'b0;
  logic ASYNC_RST_L;
  always #5 CLK = ~CLK;

  i2c_write_sequencer_if bus();

  i2c_write_sequencer #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .ASYNC_RST_L(ASYNC_RST_L),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // payload model: bytes waiting in the buffer, and bytes owed to the current transaction
  logic [7:0] mq[$];
  logic [7:0] exp_tx[$];
  logic [7:0] cap_log[$];
  logic [7:0] exp_addr;
  logic [7:0] last_addr;
  bit         model_idle = 1'b1;
  bit         exp_ok;
  int         exp_sent;
  int         tx_sent;
  int         done_cnt = 0;
  int         nack_cnt = 0;
  bit         nack_addr = 1'b0;
  int         nack_idx = -1;

  typedef enum {MI, MADDR, MRDY, MDATA, MSTOP, MDEAD} mst_t;
  mst_t m_st = MI;
  int   m_cnt;

  function automatic logic [31:0] cap(input int i);
    if (i < cap_log.size()) return {24'h0, cap_log[i]};
    return 32'hFFFF_FFFF;
  endfunction

  // Master model and checker share the falling edge: DUT outputs are settled there.
  always @(negedge CLK) begin : model
    int l;
    if (!ASYNC_RST_L) begin
      m_st            = MI;
      bus.M_RUNNING   = 1'b0;
      bus.M_BUSY      = 1'b0;
      bus.M_ADDR_SENT = 1'b0;
    end else begin
      case (m_st)
        MI: if (bus.M_START) begin
          chk("m_addr", bus.M_ADDR, exp_addr);
          last_addr     = bus.M_ADDR;
          bus.M_RUNNING = 1'b1;
          bus.M_BUSY    = 1'b1;
          m_cnt         = 3;
          m_st          = MADDR;
        end
        MADDR: begin
          m_cnt--;
          if (m_cnt == 0) begin
            if (nack_addr) begin
              bus.M_RUNNING = 1'b0;
              bus.M_BUSY    = 1'b0;
              m_st          = MDEAD;
            end else begin
              bus.M_ADDR_SENT = 1'b1;
              bus.M_BUSY      = 1'b0;
              m_st            = MRDY;
            end
          end
        end
        MRDY: if (bus.M_START) begin
          if (exp_tx.size() > 0) chk("tx_byte", bus.M_DATA, exp_tx.pop_front());
          else chk("tx_extra_byte", exp_tx.size(), 1);
          cap_log.push_back(bus.M_DATA);
          tx_sent++;
          bus.M_BUSY = 1'b1;
          m_cnt      = 4;
          m_st       = MDATA;
        end else begin
          m_cnt = 2;
          m_st  = MSTOP;
        end
        MDATA: begin
          m_cnt--;
          if (m_cnt == 0) begin
            bus.M_BUSY = 1'b0;
            if (tx_sent - 1 == nack_idx) begin
              bus.M_RUNNING   = 1'b0;
              bus.M_ADDR_SENT = 1'b0;
              m_st            = MDEAD;
            end else begin
              m_st = MRDY;
            end
          end
        end
        MSTOP: begin
          m_cnt--;
          if (m_cnt == 0) begin
            bus.M_RUNNING   = 1'b0;
            bus.M_ADDR_SENT = 1'b0;
            m_st            = MI;
          end
        end
        MDEAD: if (!bus.M_START) m_st = MI;
        default: m_st = MI;
      endcase

      chk("done_nack_excl", {31'h0, bus.DONE & bus.NACK}, 32'h0);
      if (bus.DONE || bus.NACK) begin
        chk("end_while_model_idle", {31'h0, model_idle}, 32'h0);
        chk("outcome_done", {31'h0, bus.DONE}, {31'h0, exp_ok});
        chk("bytes_sent", tx_sent, exp_sent);
        if (bus.DONE) done_cnt++;
        if (bus.NACK) nack_cnt++;
        exp_tx.delete();
        model_idle = 1'b1;
      end
      chk("idle", {31'h0, bus.IDLE}, {31'h0, model_idle});
      if (model_idle) begin
        chk("full", {31'h0, bus.FULL}, {31'h0, mq.size() == DEPTH});
        chk("m_start_idle", {31'h0, bus.M_START}, 32'h0);
      end

      // apply the inputs that the next rising edge will sample
      l = int'(bus.LEN);
      if (model_idle && bus.GO && l >= 1 && l <= DEPTH && l <= mq.size()) begin
        model_idle = 1'b0;
        exp_addr   = {bus.SLAVE, 1'b0};
        exp_tx.delete();
        for (int i = 0; i < l; i++) exp_tx.push_back(mq.pop_front());
        tx_sent  = 0;
        exp_ok   = !nack_addr && !(nack_idx >= 0 && nack_idx < l);
        exp_sent = nack_addr ? 0 : ((nack_idx >= 0 && nack_idx < l) ? nack_idx + 1 : l);
      end
      if (bus.WR_EN && mq.size() < DEPTH) mq.push_back(bus.WR_DATA);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = d;
    tick();
    bus.WR_EN = 1'b0;
  endtask

  task automatic go(input logic [6:0] s, input logic [4:0] l);
    bus.GO    = 1'b1;
    bus.SLAVE = s;
    bus.LEN   = l;
    tick();
    bus.GO = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!model_idle && n < 400) begin
      tick();
      n++;
    end
    chk(nm, {31'h0, model_idle}, 32'h1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_idle"},    {31'h0, bus.IDLE},    32'h1);
    chk({tag, "_full"},    {31'h0, bus.FULL},    32'h0);
    chk({tag, "_done"},    {31'h0, bus.DONE},    32'h0);
    chk({tag, "_nack"},    {31'h0, bus.NACK},    32'h0);
    chk({tag, "_m_start"}, {31'h0, bus.M_START}, 32'h0);
    chk({tag, "_m_addr"},  {24'h0, bus.M_ADDR},  32'h0);
    chk({tag, "_m_data"},  {24'h0, bus.M_DATA},  32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = 8'h00;
    bus.GO      = 1'b0;
    bus.SLAVE   = 7'h00;
    bus.LEN     = 5'd0;
    ASYNC_RST_L = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    ASYNC_RST_L = 1'b1;
    tick();

    // two bytes, acked throughout
    push(8'h00);
    push(8'hAF);
    cap_log.delete();
    go(7'h3C, 5'd2);
    wait_idle("t1_wait");
    chk("t1_addr", {24'h0, last_addr}, 32'h78);
    chk("t1_ncap", cap_log.size(), 2);
    chk("t1_b0", cap(0), 32'h00);
    chk("t1_b1", cap(1), 32'hAF);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_nack_cnt", nack_cnt, 0);

    // address not acked: all three bytes flushed
    push(8'h11);
    push(8'h22);
    push(8'h33);
    cap_log.delete();
    nack_addr = 1'b1;
    go(7'h05, 5'd3);
    wait_idle("t2_wait");
    nack_addr = 1'b0;
    chk("t2_addr", {24'h0, last_addr}, 32'h0A);
    chk("t2_ncap", cap_log.size(), 0);
    chk("t2_nack_cnt", nack_cnt, 1);
    chk("t2_done_cnt", done_cnt, 1);

    // no-ack on first of four bytes, two bytes left behind afterwards
    for (int i = 1; i <= 6; i++) push(8'h60 + 8'(i));
    cap_log.delete();
    nack_idx = 0;
    go(7'h50, 5'd4);
    wait_idle("t3_wait");
    nack_idx = -1;
    chk("t3_ncap", cap_log.size(), 1);
    chk("t3_b0", cap(0), 32'h61);
    chk("t3_nack_cnt", nack_cnt, 2);
    go(7'h50, 5'd3);
    chk("t3_len_over_count_ignored", {31'h0, bus.IDLE}, 32'h1);
    cap_log.delete();
    go(7'h21, 5'd2);
    wait_idle("t3b_wait");
    chk("t3b_b0", cap(0), 32'h65);
    chk("t3b_b1", cap(1), 32'h66);
    chk("t3b_done_cnt", done_cnt, 2);

    // fill to 16, 17th dropped; illegal LEN ignored
    for (int i = 0; i < 17; i++) begin
      push(8'h40 + 8'(i));
      if (i == 14) chk("t4_full_after_15", {31'h0, bus.FULL}, 32'h0);
      if (i == 15) chk("t4_full_after_16", {31'h0, bus.FULL}, 32'h1);
    end
    chk("t4_full_after_17", {31'h0, bus.FULL}, 32'h1);
    go(7'h11, 5'd0);
    chk("t4_len0_ignored", {31'h0, bus.IDLE}, 32'h1);
    go(7'h11, 5'd17);
    chk("t4_len17_ignored", {31'h0, bus.IDLE}, 32'h1);
    cap_log.delete();
    go(7'h11, 5'd16);
    wait_idle("t4_wait");
    chk("t4_ncap", cap_log.size(), 16);
    chk("t4_first", cap(0), 32'h40);
    chk("t4_last", cap(15), 32'h4F);
    chk("t4_full_drained", {31'h0, bus.FULL}, 32'h0);
    for (int i = 0; i < 4; i++) push(8'h90 + 8'(i));
    go(7'h12, 5'd5);
    chk("t4_len5_of4_ignored", {31'h0, bus.IDLE}, 32'h1);

    // reset while the first byte is being handed to the master
    cap_log.delete();
    go(7'h12, 5'd4);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      #1;
      if (cap_log.size() > 0) break;
    end
    chk("t5_handoff_reached", cap_log.size(), 1);
    ASYNC_RST_L = 1'b0;
    #1;
    chk_reset_outputs("t5_rst");
    mq.delete();
    exp_tx.delete();
    model_idle = 1'b1;
    tick();
    tick();
    ASYNC_RST_L = 1'b1;
    tick();
    chk("t5_done_cnt", done_cnt, 3);
    chk("t5_nack_cnt", nack_cnt, 2);
    push(8'hC1);
    push(8'hC2);
    cap_log.delete();
    go(7'h12, 5'd2);
    wait_idle("t5b_wait");
    chk("t5b_addr", {24'h0, last_addr}, 32'h24);
    chk("t5b_b0", cap(0), 32'hC1);
    chk("t5b_b1", cap(1), 32'hC2);
    chk("t5b_done_cnt", done_cnt, 4);

    // write and GO while a transaction is in flight
    push(8'hD1);
    push(8'hD2);
    cap_log.delete();
    go(7'h33, 5'd2);
    tick();
    tick();
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = 8'hEE;
    bus.GO      = 1'b1;
    bus.SLAVE   = 7'h7F;
    bus.LEN     = 5'd1;
    tick();
    bus.WR_EN = 1'b0;
    bus.GO    = 1'b0;
    chk("t6_busy_during_go", {31'h0, bus.IDLE}, 32'h0);
    wait_idle("t6_wait");
    chk("t6_addr", {24'h0, last_addr}, 32'h66);
    chk("t6_ncap", cap_log.size(), 2);
    chk("t6_b0", cap(0), 32'hD1);
    chk("t6_b1", cap(1), 32'hD2);
    cap_log.delete();
    go(7'h7F, 5'd1);
    wait_idle("t6b_wait");
    chk("t6b_addr", {24'h0, last_addr}, 32'hFE);
    chk("t6b_b0", cap(0), 32'hEE);
    chk("t6b_done_cnt", done_cnt, 6);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_write_sequencer.md
I2C_WRITE_SEQUENCER -- requirements
Module: i2c_write_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, payload byte buffer depth (power of two).
REQ-002 SHALL have port CLK  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port ASYNC_RST_L  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port WR_EN  input  1  push WR_DATA into payload buffer.
REQ-005 SHALL have port WR_DATA  input  8  payload byte.
REQ-006 SHALL have port FULL  output  1  payload buffer full.
REQ-007 SHALL have port GO  input  1  one-cycle request to start a write transaction.
REQ-008 SHALL have port SLAVE  input  7  7-bit slave address, sampled with GO.
REQ-009 SHALL have port LEN  input  5  payload byte count 1..DEPTH, sampled with GO.
REQ-010 SHALL have port IDLE  output  1  sequencer in IDLE state.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse, transaction completed with all bytes acked.
REQ-012 SHALL have port NACK  output  1  one-cycle pulse, transaction aborted by slave no-ack.
REQ-013 SHALL have ports M_START out 1, M_ADDR out 8, M_DATA out 8 (drives master START, ADDR, DATA).
REQ-014 SHALL have ports M_BUSY in 1, M_RUNNING in 1, M_ADDR_SENT in 1 (from master BUSY, RUNNING, ADDR_SENT); master RESTART tied 0 externally.

Function
REQ-015 Master ready condition: RDY = M_RUNNING & M_ADDR_SENT & ~M_BUSY.
REQ-016 Buffer: DEPTH x 8 FIFO; push when WR_EN & ~FULL; WR_EN while FULL ignored; push and pop in same cycle both take effect.
REQ-017 States: IDLE, ARM, WAIT_RUN, WAIT_RDY, HANDOFF, STOP, FLUSH.
REQ-018 IDLE: GO accepted only if LEN in 1..DEPTH and LEN <= buffer count; else GO ignored, no pulse.
REQ-019 On accepted GO: latch M_ADDR = {SLAVE, 1'b0} (write), remaining = LEN, assert M_START, go ARM.
REQ-020 ARM: hold M_START; when M_RUNNING=1 go WAIT_RDY.
REQ-021 WAIT_RDY: on RDY with remaining>0: M_DATA = FIFO head, pop, remaining-1, keep M_START=1, go HANDOFF.
REQ-022 WAIT_RDY: on RDY with remaining=0: drop M_START, go STOP.
REQ-023 HANDOFF: hold M_DATA stable and M_START=1 until M_BUSY=1, then go WAIT_RDY; RDY SHALL not trigger a second pop in HANDOFF.
REQ-024 STOP: wait M_RUNNING=0, then pulse DONE one cycle, go IDLE.
REQ-025 M_RUNNING falling in WAIT_RDY or HANDOFF (not STOP) = no-ack: drop M_START, go FLUSH.
REQ-026 FLUSH: pop and discard remaining bytes, one per cycle; at remaining=0 pulse NACK, go IDLE.
REQ-027 M_DATA SHALL change only on the pop cycle of REQ-021; M_ADDR only on accepted GO.
REQ-028 GO outside IDLE SHALL be ignored; WR_EN accepted in every state.
REQ-029 IDLE output = 1 exactly in IDLE; DONE and NACK never asserted together.

Reset
REQ-030 ASYNC_RST_L=0 SHALL immediately force: state IDLE, buffer empty, remaining 0, FULL 0, IDLE 1, DONE 0, NACK 0, M_START 0, M_ADDR 0, M_DATA 0.
REQ-031 Reset mid-transaction SHALL drop M_START at once and discard all buffered bytes; no DONE or NACK pulse.

Verification
REQ-032 Push 0x00,0xAF; GO SLAVE=0x3C LEN=2 with master model acking -> M_ADDR=0x78, M_DATA 0x00 then 0xAF, one DONE pulse, buffer empty.
REQ-033 Slave model no-acks address, LEN=3 -> M_START drops, 3 bytes flushed, single NACK pulse, no DONE.
REQ-034 No-ack after first of 4 bytes -> remaining 3 flushed, NACK pulse, buffer count returns to pre-GO count minus 4.
REQ-035 Push 17 bytes with DEPTH=16 -> FULL=1 after 16th, 17th dropped; GO LEN=0 or LEN=5 with 4 buffered -> ignored, IDLE stays 1.
REQ-036 Assert ASYNC_RST_L=0 during HANDOFF -> all outputs at reset values same cycle; next GO with fresh data completes normally.
REQ-037 WR_EN during active transaction plus GO in WAIT_RDY -> new byte buffered, GO ignored, transaction sends only latched LEN bytes.
